// File: rtl/sal_refresh_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sal_refresh_ctrl_pkg
// Shared DDR2 refresh constants and types for the auto-refresh sequencer.
//   - default tREFI / tRFC cycle counts and credit limits
//   - ref_state_t : refresh FSM encoding
//   - ref_cnt_t   : credit counter type for the default MAX_POSTPONE
//   - ref_cnt_w() : credit counter width for any MAX_POSTPONE
// ----------------------------------------------------------------------------
package sal_refresh_ctrl_pkg;

   localparam int REF_BK_CNT       = 4;
   localparam int REF_TREFI_CYC    = 1560;
   localparam int REF_TRFC_CYC     = 26;
   localparam int REF_MAX_POSTPONE = 8;
   localparam int REF_URGENT_TH    = 6;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      ISSUE    = 2'd2,
      WAIT_RFC = 2'd3
   } ref_state_t;

   // Width must hold MAX_POSTPONE itself, hence the +1.
   function automatic int ref_cnt_w(input int max_postpone);
      return $clog2(max_postpone + 1);
   endfunction

   typedef logic [$clog2(REF_MAX_POSTPONE+1)-1:0] ref_cnt_t;

endpackage

// File: rtl/sal_ref_timer.sv
// ----------------------------------------------------------------------------
// sal_ref_timer
// tREFI interval generator. Counts down from TREFI_CYC-1 while en is high and
// emits a registered one-cycle tick when the count expires; en low holds the
// counter at its reload value so no ticks are produced.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   en    : refresh enable
//   tick  : one-cycle pulse, one per TREFI_CYC enabled cycles
// ----------------------------------------------------------------------------
module sal_ref_timer #(
   parameter int TREFI_CYC = 1560
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int TW = (TREFI_CYC > 2) ? $clog2(TREFI_CYC) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(TREFI_CYC - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else if (!en) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt  <= RELOAD;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt - 1'b1;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/sal_refresh_ctrl.sv
// ----------------------------------------------------------------------------
// sal_refresh_ctrl
// Periodic DDR2 auto-refresh sequencer. Accumulates one credit per tREFI tick,
// drains all banks, issues one REF per credit to the scheduler and holds the
// banks for tRFC after each granted REF.
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   ref_en       : refresh enable
//   bk_idle_arr  : per-bank "no queued work"
//   bk_ack_arr   : per-bank "precharged and holding off ACTs"
//   ref_cmd_gnt  : scheduler accepted the REF this cycle
//   ref_req_arr  : per-bank refresh hold request (registered)
//   ref_cmd_req  : REF command request to scheduler (registered)
//   ref_busy     : FSM not in IDLE (registered)
//   pending_cnt  : outstanding refresh credits
//   ref_overflow : sticky, a tick was dropped with credits saturated
// Build option: SAL_REF_BURST_EN - after tRFC, go straight back to ISSUE while
// credits remain, keeping the banks held (no re-drain between REFs).
// ----------------------------------------------------------------------------
module sal_refresh_ctrl
   import sal_refresh_ctrl_pkg::*;
#(
   parameter int BK_CNT       = REF_BK_CNT,
   parameter int TREFI_CYC    = REF_TREFI_CYC,
   parameter int TRFC_CYC     = REF_TRFC_CYC,
   parameter int MAX_POSTPONE = REF_MAX_POSTPONE,
   parameter int URGENT_TH    = REF_URGENT_TH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                ref_en,
   input  logic [BK_CNT-1:0]                   bk_idle_arr,
   input  logic [BK_CNT-1:0]                   bk_ack_arr,
   input  logic                                ref_cmd_gnt,
   output logic [BK_CNT-1:0]                   ref_req_arr,
   output logic                                ref_cmd_req,
   output logic                                ref_busy,
   output logic [$clog2(MAX_POSTPONE+1)-1:0]   pending_cnt,
   output logic                                ref_overflow
);

   localparam int CNT_W = ref_cnt_w(MAX_POSTPONE);
   localparam int RFC_W = (TRFC_CYC > 2) ? $clog2(TRFC_CYC) : 1;

   ref_state_t       state, state_nxt;
   logic             tick, grant, urgent, ovf_set;
   logic [CNT_W-1:0] pend_nxt;
   logic [RFC_W-1:0] rfc_cnt;

   sal_ref_timer #(.TREFI_CYC(TREFI_CYC)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ref_en),
      .tick  (tick)
   );

   // ref_cmd_req is only ever high in ISSUE, so it also qualifies the grant;
   // a stray grant in any other state is ignored.
   assign grant  = ref_cmd_req & ref_cmd_gnt;
   assign urgent = pending_cnt >= CNT_W'(URGENT_TH);

   // Credit bookkeeping: tick and grant together cancel out.
   always_comb begin
      pend_nxt = pending_cnt;
      ovf_set  = 1'b0;
      if (tick && !grant) begin
         if (pending_cnt == CNT_W'(MAX_POSTPONE)) ovf_set  = 1'b1;
         else                                     pend_nxt = pending_cnt + 1'b1;
      end else if (grant && !tick && pending_cnt != '0) begin
         pend_nxt = pending_cnt - 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (pending_cnt != '0 && (urgent || &bk_idle_arr)) state_nxt = DRAIN;
         DRAIN:    if (&bk_ack_arr) state_nxt = ISSUE;
         ISSUE:    if (grant) state_nxt = WAIT_RFC;
         WAIT_RFC: if (rfc_cnt == '0) begin
`ifdef SAL_REF_BURST_EN
            // pend_nxt already includes a tick landing this cycle.
            state_nxt = (pend_nxt != '0) ? ISSUE : IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rfc_cnt      <= '0;
         pending_cnt  <= '0;
         ref_overflow <= 1'b0;
         ref_req_arr  <= '0;
         ref_cmd_req  <= 1'b0;
         ref_busy     <= 1'b0;
      end else begin
         state       <= state_nxt;
         pending_cnt <= pend_nxt;
         if (ovf_set) ref_overflow <= 1'b1;

         if (grant)                               rfc_cnt <= RFC_W'(TRFC_CYC - 1);
         else if (state == WAIT_RFC && rfc_cnt != '0) rfc_cnt <= rfc_cnt - 1'b1;

         // Outputs decoded from the next state so they line up with it.
         ref_req_arr <= (state_nxt != IDLE) ? '1 : '0;
         ref_cmd_req <= (state_nxt == ISSUE);
         ref_busy    <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_sal_refresh_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sal_refresh_ctrl
// Directed bench for sal_refresh_ctrl with TREFI=100, TRFC=10, MAX=4,
// URGENT=2, 4 banks. A per-cycle responder acks banks one cycle after the
// hold request (through ack_mask) and grants REF immediately (gnt_en).
// Each grant pushes the cycle at which the bank hold must drop; the drop is
// popped and compared when it happens.
// ----------------------------------------------------------------------------
module tb_sal_refresh_ctrl;

   localparam int BK    = 4;
   localparam int TREFI = 100;
   localparam int TRFC  = 10;
   localparam int MAXP  = 4;
   localparam int URG   = 2;
`ifdef SAL_REF_BURST_EN
   localparam int GNT_SPACING = TRFC + 1;
   localparam int FLUSH_RISES = 0;
`else
   localparam int GNT_SPACING = TRFC + 3;
   localparam int FLUSH_RISES = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ref_en = 1'b0;
   logic [BK-1:0] bk_idle_arr = '0;
   logic [BK-1:0] bk_ack_arr = '0;
   logic          ref_cmd_gnt = 1'b0;
   logic [BK-1:0] ref_req_arr;
   logic          ref_cmd_req;
   logic          ref_busy;
   logic [2:0]    pending_cnt;
   logic          ref_overflow;

   int checks = 0;
   int fails  = 0;

   int            n = 0;
   int            grants = 0, rises = 0, gnt_edge = 0, spacing = 0, last_inc = 0;
   logic [BK-1:0] ack_mask = '1;
   logic          gnt_en = 1'b1;
   logic [BK-1:0] prev_req = '0;
   logic          prev_cmd = 1'b0;
   logic [2:0]    prev_pend = '0;
   int            sb[$];

   sal_refresh_ctrl #(
      .BK_CNT(BK), .TREFI_CYC(TREFI), .TRFC_CYC(TRFC),
      .MAX_POSTPONE(MAXP), .URGENT_TH(URG)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ref_en       (ref_en),
      .bk_idle_arr  (bk_idle_arr),
      .bk_ack_arr   (bk_ack_arr),
      .ref_cmd_gnt  (ref_cmd_gnt),
      .ref_req_arr  (ref_req_arr),
      .ref_cmd_req  (ref_cmd_req),
      .ref_busy     (ref_busy),
      .pending_cnt  (pending_cnt),
      .ref_overflow (ref_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // One clock: observe just after the edge, score events, drive responses.
   task automatic cyc();
      @(posedge clk);
      n++;
      #1;
      if (ref_cmd_gnt && prev_cmd && rst_n) begin
         if (grants > 0) spacing = n - gnt_edge;
         grants++;
         gnt_edge = n;
         chk("cmd_req_drop_after_gnt", ref_cmd_req, 1'b0);
`ifdef SAL_REF_BURST_EN
         if (pending_cnt == '0) sb.push_back(n + TRFC);
`else
         sb.push_back(n + TRFC);
`endif
      end
      if (prev_req != '0 && ref_req_arr == '0) begin
         if (sb.size() == 0) chk("req_drop_expected", 0, 1);
         else                chk("req_drop_cycle", n, sb.pop_front());
      end
      if (prev_req == '0 && ref_req_arr != '0) rises++;
      if (pending_cnt > prev_pend) last_inc = n;
      prev_req    = ref_req_arr;
      prev_cmd    = ref_cmd_req;
      prev_pend   = pending_cnt;
      ref_cmd_gnt = gnt_en && ref_cmd_req;
      bk_ack_arr  = ref_req_arr & ack_mask;
   endtask

   initial begin
      int n0, t0, g0, r0;

      // ---- reset state
      #3;
      chk("rst_req", ref_req_arr, 0);
      chk("rst_cmd", ref_cmd_req, 0);
      chk("rst_busy", ref_busy, 0);
      chk("rst_pend", pending_cnt, 0);
      chk("rst_ovf", ref_overflow, 0);
      cyc(); cyc();

      // ---- idle banks: first tick, one full sequence
      rst_n = 1'b1; ref_en = 1'b1; bk_idle_arr = '1; n0 = n;
      for (int i = 0; i < 150 && pending_cnt == '0; i++) cyc();
      // tick registered 100 cycles after enable; credit lands one edge later
      chk("first_credit_edge", n - n0, TREFI + 1);
      cyc();
      chk("idle_req_all", ref_req_arr, 4'hF);
      chk("idle_busy", ref_busy, 1);
      for (int i = 0; i < 10 && grants == 0; i++) cyc();
      chk("idle_one_grant", grants, 1);
      repeat (12) cyc();
      chk("idle_sb_empty", sb.size(), 0);
      chk("idle_req_off", ref_req_arr, 0);
      chk("idle_pend_zero", pending_cnt, 0);
      chk("idle_busy_off", ref_busy, 0);

      // ---- busy banks: no request until urgent
      bk_idle_arr = '0;
      for (int i = 0; i < 120 && pending_cnt != 3'd1; i++) cyc();
      repeat (20) cyc();
      chk("busy_pend1", pending_cnt, 1);
      chk("busy_no_req", ref_req_arr, 0);
      chk("busy_not_busy", ref_busy, 0);
      for (int i = 0; i < 110 && pending_cnt != 3'd2; i++) cyc();
      chk("busy_pend2", pending_cnt, 2);
      cyc();
      chk("urgent_forced_req", ref_req_arr, 4'hF);
      g0 = grants;
      for (int i = 0; i < 10 && grants == g0; i++) cyc();
      chk("urgent_grant", grants - g0, 1);
      for (int i = 0; i < 40 && ref_busy; i++) cyc();
      chk("urgent_done_req", ref_req_arr, 0);

      // ---- grant aligned with a tick at pending_cnt=1
      for (int i = 0; i < 120 && !(pending_cnt == 3'd1 && !ref_busy); i++) cyc();
      t0 = last_inc;
      for (int i = 0; i < 200 && n < t0 + TREFI - 3; i++) cyc();
      bk_idle_arr = '1;
      cyc(); cyc(); cyc();
      chk("align_grant_edge", gnt_edge, t0 + TREFI);
      chk("align_pend_held", pending_cnt, 1);
      for (int i = 0; i < 60 && (pending_cnt != '0 || ref_busy); i++) cyc();
      chk("align_drained", pending_cnt, 0);

      // ---- overflow: partial acks withheld, credits saturate
      ack_mask = 4'b1011;
      for (int i = 0; i < 450 && pending_cnt != 3'd4; i++) cyc();
      t0 = n;
      chk("ovf_sat_pend", pending_cnt, MAXP);
      chk("ovf_not_yet", ref_overflow, 0);
      for (int i = 0; i < 120 && !ref_overflow; i++) cyc();
      chk("ovf_fifth_tick", n - t0, TREFI);
      chk("ovf_pend_max", pending_cnt, MAXP);
      chk("ovf_req_held", ref_req_arr, 4'hF);
      chk("ovf_no_cmd", ref_cmd_req, 0);
      ack_mask = '1; g0 = grants;
      for (int i = 0; i < 200 && (pending_cnt != '0 || ref_busy); i++) cyc();
      chk("ovf_flush_grants", grants - g0, MAXP);
      chk("ovf_sticky", ref_overflow, 1);

      // ---- three credits flushed
      ack_mask = '0; bk_idle_arr = '0;
      for (int i = 0; i < 300 && pending_cnt != 3'd3; i++) cyc();
      chk("flush_pend3", pending_cnt, 3);
      ack_mask = '1; bk_idle_arr = '1; g0 = grants; r0 = rises;
      for (int i = 0; i < 100 && (pending_cnt != '0 || ref_busy); i++) cyc();
      chk("flush_grants", grants - g0, 3);
      chk("flush_redrains", rises - r0, FLUSH_RISES);
      chk("flush_spacing", spacing, GNT_SPACING);
      chk("flush_sb_empty", sb.size(), 0);

      // ---- reset in the middle of WAIT_RFC
      ack_mask = '0;
      for (int i = 0; i < 300 && pending_cnt != 3'd2; i++) cyc();
      ack_mask = '1; g0 = grants;
      for (int i = 0; i < 10 && grants == g0; i++) cyc();
      repeat (3) cyc();
      chk("mid_rfc_busy", ref_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", ref_req_arr, 0);
      chk("mid_rst_cmd", ref_cmd_req, 0);
      chk("mid_rst_busy", ref_busy, 0);
      chk("mid_rst_pend", pending_cnt, 0);
      chk("mid_rst_ovf", ref_overflow, 0);
      sb.delete(); prev_req = '0; prev_cmd = 1'b0; prev_pend = '0;
      ref_cmd_gnt = 1'b0; bk_ack_arr = '0;
      cyc();
      rst_n = 1'b1; n0 = n;
      for (int i = 0; i < 150 && pending_cnt == '0; i++) cyc();
      chk("post_rst_credit_edge", n - n0, TREFI + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
